// File: rtl/logic_serial_16bit_chip.sv
// Nibble-serial 16-bit logic unit: OR/AND/XOR/NOT computed four bits per cycle.
// A start in IDLE latches the operands; the result appears on out with a done pulse four edges later.
module logic_serial_16bit_chip (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic        zero
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  cnt;
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] result;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  nib;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start)      next_state = BUSY;
      BUSY: if (cnt == 2'd3) next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
  end

  // Nibble slice selected by the counter, LSB nibble first.
  always_comb begin
    nib_a = a_q[{cnt, 2'b00} +: 4];
    nib_b = b_q[{cnt, 2'b00} +: 4];
    nib   = 4'h0;
    case (op_q)
      2'b00: nib = nib_a | nib_b;
      2'b01: nib = nib_a & nib_b;
      2'b10: nib = nib_a ^ nib_b;
      2'b11: nib = ~nib_a;
    endcase
  end

  // out is written only on the last nibble, so partial results never leak.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 2'd0;
      op_q   <= 2'b00;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      result <= 16'h0000;
      out    <= 16'h0000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= 2'd0;
          end
        end
        BUSY: begin
          result[{cnt, 2'b00} +: 4] <= nib;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            out  <= {nib, result[11:0]};
            done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign zero = (out == 16'h0000);

endmodule

// File: tb/tb_logic_serial_16bit_chip.sv
// Self-checking bench for logic_serial_16bit_chip: vector table plus directed
// multi-cycle sequences, with expected results queued at start and popped at done.
module tb_logic_serial_16bit_chip;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        zero;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] sb[$];
  logic [15:0] lastOut;
  int          checks;
  int          errors;

  logic_serial_16bit_chip dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setVec(input int idx, input logic [1:0] vop, input logic [15:0] va,
                        input logic [15:0] vb, input logic [15:0] vexp, input string vname);
    vecs[idx].op   = vop;
    vecs[idx].a    = va;
    vecs[idx].b    = vb;
    vecs[idx].exp  = vexp;
    vecs[idx].name = vname;
  endtask

  // Drives one start cycle and queues the result the operation must produce.
  task automatic applyStimulus(input logic [1:0] vop, input logic [15:0] va,
                               input logic [15:0] vb, input logic [15:0] vexp);
    op    = vop;
    a     = va;
    b     = vb;
    start = 1'b1;
    sb.push_back(vexp);
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checking out holds and busy stays high meanwhile.
  task automatic waitDone(input string name, input int startCyc);
    int          cyc;
    logic [15:0] exp;
    cyc = startCyc;
    while (done !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
      if (done !== 1'b1) begin
        checkOutput({name, " hold"}, out, lastOut);
        checkOutput({name, " busy"}, {15'b0, busy}, 16'd1);
      end
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done expected done", name);
    end else begin
      checkOutput({name, " latency"}, 16'(cyc), 16'd4);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: got done expected no done", name);
      end else begin
        exp = sb.pop_front();
        checkOutput(name, out, exp);
        checkOutput({name, " zero"}, {15'b0, zero}, {15'b0, exp == 16'h0000});
        checkOutput({name, " idle"}, {15'b0, busy}, 16'd0);
        lastOut = exp;
      end
    end
  endtask

  task automatic runOp(input logic [1:0] vop, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] vexp, input string name);
    applyStimulus(vop, va, vb, vexp);
    checkOutput({name, " accept"}, {15'b0, busy}, 16'd1);
    waitDone(name, 0);
    tick();
    checkOutput({name, " pulse"}, {15'b0, done}, 16'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    lastOut = 16'h0000;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = 16'h0000;
    b       = 16'h0000;

    setVec(0, 2'b00, 16'hA38C, 16'hC707, 16'hE78F, "or a38c");
    setVec(1, 2'b00, 16'h0000, 16'hFFFF, 16'hFFFF, "or 0/ffff");
    setVec(2, 2'b00, 16'hFFFF, 16'h0000, 16'hFFFF, "or ffff/0");
    setVec(3, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, "and ffff/0");
    setVec(4, 2'b01, 16'h1234, 16'hFF00, 16'h1200, "and 1234");
    setVec(5, 2'b10, 16'h00FF, 16'h0F0F, 16'h0FF0, "xor 00ff");
    setVec(6, 2'b10, 16'hFFFF, 16'hFFFF, 16'h0000, "xor ffff");
    setVec(7, 2'b11, 16'h0000, 16'h1234, 16'hFFFF, "not 0000");
    setVec(8, 2'b11, 16'hFFFF, 16'hABCD, 16'h0000, "not ffff");

    // Reset then idle
    tick();
    tick();
    checkOutput("reset out", out, 16'h0000);
    checkOutput("reset busy", {15'b0, busy}, 16'd0);
    checkOutput("reset done", {15'b0, done}, 16'd0);
    checkOutput("reset zero", {15'b0, zero}, 16'd1);
    reset = 1'b0;
    tick();
    checkOutput("idle out", out, 16'h0000);
    checkOutput("idle busy", {15'b0, busy}, 16'd0);

    for (int i = 0; i < 9; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Back-to-back AND/XOR/NOT, restarting in each done cycle
    applyStimulus(2'b01, 16'hA38C, 16'hC707, 16'h8304);
    waitDone("b2b and", 0);
    applyStimulus(2'b10, 16'hA38C, 16'hC707, 16'h648B);
    checkOutput("b2b xor done fall", {15'b0, done}, 16'd0);
    checkOutput("b2b xor busy rise", {15'b0, busy}, 16'd1);
    waitDone("b2b xor", 0);
    applyStimulus(2'b11, 16'hA38C, 16'hC707, 16'h5C73);
    checkOutput("b2b not done fall", {15'b0, done}, 16'd0);
    waitDone("b2b not", 0);
    tick();
    checkOutput("b2b not pulse", {15'b0, done}, 16'd0);

    // Operand change and start while busy are ignored
    applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0000);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("busy start", 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("busy start one done", {15'b0, done}, 16'd0);
      checkOutput("busy start stays idle", {15'b0, busy}, 16'd0);
    end

    // Start held high restarts on every idle cycle
    op    = 2'b10;
    a     = 16'hFFFF;
    b     = 16'h00FF;
    start = 1'b1;
    sb.push_back(16'hFF00);
    sb.push_back(16'hFF00);
    tick();
    waitDone("held 1", 0);
    tick();
    start = 1'b0;
    checkOutput("held restart busy", {15'b0, busy}, 16'd1);
    checkOutput("held restart done", {15'b0, done}, 16'd0);
    waitDone("held 2", 0);
    tick();

    // Reset mid-operation, with start also high at the reset edge
    applyStimulus(2'b00, 16'hFFFF, 16'h0000, 16'hFFFF);
    tick();
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    sb.delete();
    lastOut = 16'h0000;
    checkOutput("midreset out", out, 16'h0000);
    checkOutput("midreset busy", {15'b0, busy}, 16'd0);
    checkOutput("midreset zero", {15'b0, zero}, 16'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midreset no done", {15'b0, done}, 16'd0);
    end
    runOp(2'b00, 16'h0001, 16'h0000, 16'h0001, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
